axi_lite_timer: RTL and testbench

AXI4-Lite responder hanging off crossbar slave port 3 (base 0x0000_3000, mask 0x0FFF), giving the ROC_RV32 core a 64-bit free-running timer with a 64-bit compare and an interrupt line. It accepts the same AXI4-Lite channel set the LSU interconnect drives: independent AW/W acceptance, a held B response, and a registered R response.

---
 rtl/axi_timer_pkg.sv | 74 +++++++
 rtl/axi_timer_core.sv | 103 ++++++++++
 rtl/axi_lite_timer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_axi_lite_timer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_timer_pkg.sv
// ============================================================================
//  Module      : axi_timer_pkg
//  Description : Shared definitions for the AXI4-Lite 64-bit timer: register
//                offsets, CTRL/STATUS bit positions, AXI response codes,
//                channel FSM state types and small decode/merge helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_timer_pkg;

  // Register byte offsets (only addr[4:0] is decoded)
  localparam logic [4:0] OFS_CTRL     = 5'h00;
  localparam logic [4:0] OFS_PRESCALE = 5'h04;
  localparam logic [4:0] OFS_COUNT_LO = 5'h08;
  localparam logic [4:0] OFS_COUNT_HI = 5'h0C;
  localparam logic [4:0] OFS_CMP_LO   = 5'h10;
  localparam logic [4:0] OFS_CMP_HI   = 5'h14;
  localparam logic [4:0] OFS_STATUS   = 5'h18;

  // Bit positions
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int STATUS_MATCH_BIT = 0;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write channel FSM: which half of the AW/W pair has been latched
  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_GOT_AW = 2'd1,
    WR_GOT_W  = 2'd2,
    WR_RESP   = 2'd3
  } wr_state_e;

  // Read channel FSM
  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_VALID = 1'b1
  } rd_state_e;

  // Per-register write enables produced by the address decode
  typedef struct packed {
    logic ctrl;
    logic prescale;
    logic cnt_lo;
    logic cnt_hi;
    logic cmp_lo;
    logic cmp_hi;
    logic status;
  } reg_we_t;

  // Byte-lane merge: strb[i] selects byte i of new_val over old_val
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  // Word-aligned and inside the implemented register window
  function automatic logic reg_addr_ok(input logic [4:0] a);
    return (a[1:0] == 2'b00) && (a < 5'h1C);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_timer_core.sv
// ============================================================================
//  Module      : axi_timer_core
//  Description : Prescaler, 64-bit free-running counter, 64-bit compare
//                register and sticky MATCH flag.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   system clock
//    nrst       in   asynchronous active-low reset
//    i_en       in   CTRL.EN
//    i_we       in   decoded register write enables (one-cycle strobes)
//    i_wdata    in   write data for the strobed register
//    i_wstrb    in   byte strobes for the strobed register
//    o_count    out  current 64-bit count
//    o_cmp      out  current 64-bit compare value
//    o_prescale out  current prescale value
//    o_match    out  STATUS.MATCH
// ============================================================================
`default_nettype none

module axi_timer_core
  import axi_timer_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_en,
  input  reg_we_t     i_we,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic [63:0] o_count,
  output logic [63:0] o_cmp,
  output logic [15:0] o_prescale,
  output logic        o_match
);

  logic [15:0] r_prescale;
  logic [15:0] r_pcnt;
  logic [63:0] r_count;
  logic [63:0] r_cmp;
  logic        r_match;

  logic        w_tick;
  logic        w_cnt_wr;
  logic        w_w1c;

  assign w_tick   = i_en && (r_pcnt == r_prescale);
  assign w_cnt_wr = i_we.cnt_lo || i_we.cnt_hi;
  assign w_w1c    = i_we.status && i_wstrb[0] && i_wdata[STATUS_MATCH_BIT];

  // A software write to either count word takes priority over the tick and
  // restarts the prescaler so the new value gets a full prescale period.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pcnt  <= '0;
      r_count <= '0;
    end else if (w_cnt_wr) begin
      r_pcnt <= '0;
      if (i_we.cnt_lo) r_count[31:0]  <= apply_wstrb(r_count[31:0],  i_wdata, i_wstrb);
      if (i_we.cnt_hi) r_count[63:32] <= apply_wstrb(r_count[63:32], i_wdata, i_wstrb);
    end else if (!i_en) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt  <= '0;
      r_count <= r_count + 64'd1;
    end else begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_prescale <= '0;
      r_cmp      <= '1;
    end else begin
      if (i_we.prescale) begin
        if (i_wstrb[0]) r_prescale[7:0]  <= i_wdata[7:0];
        if (i_wstrb[1]) r_prescale[15:8] <= i_wdata[15:8];
      end
      if (i_we.cmp_lo) r_cmp[31:0]  <= apply_wstrb(r_cmp[31:0],  i_wdata, i_wstrb);
      if (i_we.cmp_hi) r_cmp[63:32] <= apply_wstrb(r_cmp[63:32], i_wdata, i_wstrb);
    end
  end

  // Set condition beats a same-cycle clear, so MATCH cannot be cleared while
  // count is still at or above cmp.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_match <= 1'b0;
    end else if (r_count >= r_cmp) begin
      r_match <= 1'b1;
    end else if (w_w1c) begin
      r_match <= 1'b0;
    end
  end

  assign o_count    = r_count;
  assign o_cmp      = r_cmp;
  assign o_prescale = r_prescale;
  assign o_match    = r_match;

endmodule

`default_nettype wire

// File: rtl/axi_lite_timer.sv
// ============================================================================
//  Module      : axi_lite_timer
//  Description : AXI4-Lite responder exposing a 64-bit free-running timer with
//                64-bit compare and a level interrupt. Holds the AW/W/B and
//                AR/R channel FSMs, the address decode and the read mux.
//  Revision    : 1.0 - initial release
//
//  Build option
//    TIMER_SNAPSHOT_EN : when defined, reading COUNT_LO latches count[63:32]
//                        into a shadow that COUNT_HI then returns.
//
//  Ports
//    clk, nrst                        clock, asynchronous active-low reset
//    awaddr/awprot/awvalid/awready    write address channel (awprot ignored)
//    wdata/wstrb/wvalid/wready        write data channel
//    bresp/bvalid/bready              write response channel
//    araddr/arprot/arvalid/arready    read address channel (arprot ignored)
//    rdata/rresp/rvalid/rready        read data channel
//    irq                              STATUS.MATCH & CTRL.IRQ_EN
// ============================================================================
`default_nettype none

module axi_lite_timer
  import axi_timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    irq
);

  // ---------------- write channel ----------------
  wr_state_e   r_wr_state;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [4:0]  r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_ctrl;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_commit;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic        w_wr_ok;
  reg_we_t     w_we;

  // ---------------- read channel ----------------
  rd_state_e   r_rd_state;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_ar_hs;
  logic [4:0]  w_rd_addr;
  logic [31:0] w_rd_mux;

  // ---------------- core ----------------
  logic [63:0] w_count;
  logic [63:0] w_cmp;
  logic [15:0] w_prescale;
  logic        w_match;

  logic        w_unused_ok;
  assign w_unused_ok = ^{awprot, arprot, awaddr[ADDR_WIDTH-1:5], araddr[ADDR_WIDTH-1:5]};

  assign w_aw_hs = awvalid && r_awready;
  assign w_w_hs  = wvalid && r_wready;

  // The write commits on the edge where the second half of the AW/W pair is
  // accepted, so the register update and bvalid appear together one cycle
  // after the completing handshake.
  always_comb begin
    w_commit = 1'b0;
    case (r_wr_state)
      WR_IDLE:   w_commit = w_aw_hs && w_w_hs;
      WR_GOT_AW: w_commit = w_w_hs;
      WR_GOT_W:  w_commit = w_aw_hs;
      default:   w_commit = 1'b0;
    endcase
  end

  assign w_wr_addr = (r_wr_state == WR_GOT_AW) ? r_awaddr : awaddr[4:0];
  assign w_wr_data = (r_wr_state == WR_GOT_W)  ? r_wdata  : wdata;
  assign w_wr_strb = (r_wr_state == WR_GOT_W)  ? r_wstrb  : wstrb;
  assign w_wr_ok   = reg_addr_ok(w_wr_addr);

  always_comb begin
    w_we = '0;
    if (w_commit && w_wr_ok) begin
      case (w_wr_addr)
        OFS_CTRL:     w_we.ctrl     = 1'b1;
        OFS_PRESCALE: w_we.prescale = 1'b1;
        OFS_COUNT_LO: w_we.cnt_lo   = 1'b1;
        OFS_COUNT_HI: w_we.cnt_hi   = 1'b1;
        OFS_CMP_LO:   w_we.cmp_lo   = 1'b1;
        OFS_CMP_HI:   w_we.cmp_hi   = 1'b1;
        OFS_STATUS:   w_we.status   = 1'b1;
        default:      w_we          = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b1;
      r_wready   <= 1'b1;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      if (w_aw_hs) r_awaddr <= awaddr[4:0];
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      case (r_wr_state)
        WR_IDLE, WR_GOT_AW, WR_GOT_W: begin
          if (w_commit) begin
            r_wr_state <= WR_RESP;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b1;
            r_bresp    <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
          end else if (w_aw_hs) begin
            r_wr_state <= WR_GOT_AW;
            r_awready  <= 1'b0;
          end else if (w_w_hs) begin
            r_wr_state <= WR_GOT_W;
            r_wready   <= 1'b0;
          end
        end
        WR_RESP: begin
          if (bready) begin
            r_wr_state <= WR_IDLE;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_bvalid   <= 1'b0;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ctrl <= '0;
    end else if (w_we.ctrl && w_wr_strb[0]) begin
      r_ctrl <= w_wr_data[1:0];
    end
  end

  axi_timer_core u_core (
    .clk        (clk),
    .nrst       (nrst),
    .i_en       (r_ctrl[CTRL_EN_BIT]),
    .i_we       (w_we),
    .i_wdata    (w_wr_data),
    .i_wstrb    (w_wr_strb),
    .o_count    (w_count),
    .o_cmp      (w_cmp),
    .o_prescale (w_prescale),
    .o_match    (w_match)
  );

  // ---------------- read path ----------------
  assign w_ar_hs   = arvalid && r_arready;
  assign w_rd_addr = araddr[4:0];

`ifdef TIMER_SNAPSHOT_EN
  logic [31:0] r_count_hi_shadow;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count_hi_shadow <= '0;
    end else if (w_ar_hs && (w_rd_addr == OFS_COUNT_LO)) begin
      r_count_hi_shadow <= w_count[63:32];
    end
  end
`endif

  // Samples register state as it stands before any same-cycle write commit.
  always_comb begin
    w_rd_mux = '0;
    case (w_rd_addr)
      OFS_CTRL:     w_rd_mux = {30'b0, r_ctrl};
      OFS_PRESCALE: w_rd_mux = {16'b0, w_prescale};
      OFS_COUNT_LO: w_rd_mux = w_count[31:0];
`ifdef TIMER_SNAPSHOT_EN
      OFS_COUNT_HI: w_rd_mux = r_count_hi_shadow;
`else
      OFS_COUNT_HI: w_rd_mux = w_count[63:32];
`endif
      OFS_CMP_LO:   w_rd_mux = w_cmp[31:0];
      OFS_CMP_HI:   w_rd_mux = w_cmp[63:32];
      OFS_STATUS:   w_rd_mux = {31'b0, w_match};
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b1;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_rd_state <= RD_VALID;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rdata    <= reg_addr_ok(w_rd_addr) ? w_rd_mux : 32'h0;
            r_rresp    <= reg_addr_ok(w_rd_addr) ? RESP_OKAY : RESP_SLVERR;
          end
        end
        RD_VALID: begin
          if (rready) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign irq     = w_match && r_ctrl[CTRL_IRQ_EN_BIT];

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_timer.sv
// ============================================================================
//  Module      : tb_axi_lite_timer
//  Description : Self-checking bench for axi_lite_timer. A reference model of
//                the timer registers is advanced once per clock and predicts
//                read data, responses and the interrupt line.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_timer;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        irq;

  always #5 clk = ~clk;

  axi_lite_timer dut (
    .clk     (clk),
    .nrst    (nrst),
    .awaddr  (awaddr),
    .awprot  (awprot),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arprot  (arprot),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .irq     (irq)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model state ----------------
  bit        m_en, m_irq_en, m_match;
  bit [15:0] m_pre, m_pcnt;
  bit [63:0] m_cnt, m_cmp;
  bit [31:0] m_shadow;

  // Transactions that complete on the next rising edge
  bit        p_rd, p_wr;
  bit [31:0] p_rd_addr, p_wr_addr, p_wdata;
  bit [3:0]  p_wstrb;

  bit [31:0] exp_rdata;
  bit [1:0]  exp_rresp, exp_bresp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_irq_en = 0; m_match = 0;
    m_pre = 0; m_pcnt = 0; m_cnt = 0; m_cmp = '1; m_shadow = 0;
    p_rd = 0; p_wr = 0;
  endtask

  function automatic bit addr_ok(input bit [31:0] a);
    return (a[1:0] == 2'b00) && (a[4:0] < 5'h1C);
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] s);
    bit [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic bit [31:0] model_read(input bit [4:0] a);
    case (a)
      5'h00: return {30'h0, m_irq_en, m_en};
      5'h04: return {16'h0, m_pre};
      5'h08: return m_cnt[31:0];
`ifdef TIMER_SNAPSHOT_EN
      5'h0C: return m_shadow;
`else
      5'h0C: return m_cnt[63:32];
`endif
      5'h10: return m_cmp[31:0];
      5'h14: return m_cmp[63:32];
      5'h18: return {31'h0, m_match};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: apply the timer rules to the model on the rising edge, then
  // compare the interrupt line on the falling edge.
  task automatic cyc();
    bit        wr_hit, nm;
    bit [4:0]  wa;
    bit [31:0] tmp;
    @(posedge clk);
    if (p_rd) begin
      if (addr_ok(p_rd_addr)) begin
        exp_rdata = model_read(p_rd_addr[4:0]);
        exp_rresp = 2'b00;
      end else begin
        exp_rdata = 32'h0;
        exp_rresp = 2'b10;
      end
`ifdef TIMER_SNAPSHOT_EN
      if (p_rd_addr[4:0] == 5'h08) m_shadow = m_cnt[63:32];
`endif
    end
    wr_hit = p_wr && addr_ok(p_wr_addr);
    wa     = p_wr_addr[4:0];
    if (m_cnt >= m_cmp) nm = 1;
    else if (wr_hit && wa == 5'h18 && p_wstrb[0] && p_wdata[0]) nm = 0;
    else nm = m_match;
    if (wr_hit && (wa == 5'h08 || wa == 5'h0C)) begin
      if (wa == 5'h08) m_cnt[31:0]  = merge(m_cnt[31:0],  p_wdata, p_wstrb);
      else             m_cnt[63:32] = merge(m_cnt[63:32], p_wdata, p_wstrb);
      m_pcnt = 0;
    end else if (!m_en) begin
      m_pcnt = 0;
    end else if (m_pcnt == m_pre) begin
      m_cnt  = m_cnt + 1;
      m_pcnt = 0;
    end else begin
      m_pcnt = m_pcnt + 1;
    end
    if (wr_hit) begin
      case (wa)
        5'h00: if (p_wstrb[0]) {m_irq_en, m_en} = p_wdata[1:0];
        5'h04: begin tmp = merge({16'h0, m_pre}, p_wdata, p_wstrb); m_pre = tmp[15:0]; end
        5'h10: m_cmp[31:0]  = merge(m_cmp[31:0],  p_wdata, p_wstrb);
        5'h14: m_cmp[63:32] = merge(m_cmp[63:32], p_wdata, p_wstrb);
        default: ;
      endcase
    end
    m_match = nm;
    if (p_wr) exp_bresp = wr_hit ? 2'b00 : 2'b10;
    p_rd = 0;
    p_wr = 0;
    @(negedge clk);
    check("irq", irq, m_match & m_irq_en);
  endtask

  // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW.
  task automatic axi_write(input bit [31:0] a, input bit [31:0] d, input bit [3:0] s,
                           input int lead, input int bdelay);
    int n;
    n = (lead < 0) ? -lead : lead;
    if (lead >= 0) begin awaddr = a; awvalid = 1; end
    if (lead <= 0) begin wdata = d; wstrb = s; wvalid = 1; end
    check("awready_idle", awready, 1);
    check("wready_idle", wready, 1);
    if (lead != 0) begin
      cyc();
      if (lead > 0) awvalid = 0; else wvalid = 0;
      repeat (n - 1) begin
        if (lead > 0) check("awready_held", awready, 0); else check("wready_held", wready, 0);
        cyc();
      end
      if (lead > 0) begin
        check("awready_held", awready, 0);
        wdata = d; wstrb = s; wvalid = 1;
      end else begin
        check("wready_held", wready, 0);
        awaddr = a; awvalid = 1;
      end
    end
    p_wr = 1; p_wr_addr = a; p_wdata = d; p_wstrb = s;
    cyc();
    awvalid = 0; wvalid = 0;
    check("bvalid", bvalid, 1);
    check("bresp", bresp, exp_bresp);
    repeat (bdelay) begin
      cyc();
      check("bvalid_hold", bvalid, 1);
    end
    bready = 1;
    cyc();
    bready = 0;
    check("bvalid_clr", bvalid, 0);
    check("awready_back", awready, 1);
  endtask

  task automatic axi_read(input bit [31:0] a, input int rdelay, output bit [31:0] got);
    araddr = a; arvalid = 1;
    check("arready_idle", arready, 1);
    p_rd = 1; p_rd_addr = a;
    cyc();
    arvalid = 0;
    check("rvalid", rvalid, 1);
    check("rdata", rdata, exp_rdata);
    check("rresp", rresp, exp_rresp);
    check("arready_busy", arready, 0);
    repeat (rdelay) begin
      cyc();
      check("rdata_hold", rdata, exp_rdata);
    end
    got = rdata;
    rready = 1;
    cyc();
    rready = 0;
    check("rvalid_clr", rvalid, 0);
  endtask

  task automatic rw_same(input bit [31:0] a, input bit [31:0] d, output bit [31:0] got);
    araddr = a; arvalid = 1;
    awaddr = a; awvalid = 1; wdata = d; wstrb = 4'hF; wvalid = 1;
    p_rd = 1; p_rd_addr = a;
    p_wr = 1; p_wr_addr = a; p_wdata = d; p_wstrb = 4'hF;
    cyc();
    arvalid = 0; awvalid = 0; wvalid = 0;
    check("rw_rvalid", rvalid, 1);
    check("rw_bvalid", bvalid, 1);
    check("rw_rdata", rdata, exp_rdata);
    check("rw_bresp", bresp, exp_bresp);
    got = rdata;
    rready = 1; bready = 1;
    cyc();
    rready = 0; bready = 0;
    check("rw_rvalid_clr", rvalid, 0);
    check("rw_bvalid_clr", bvalid, 0);
  endtask

  localparam bit [31:0] BASE = 32'h0000_3000;

  initial begin
    bit [31:0] g1, g2, old;
    bit [31:0] off, d;
    bit [3:0]  s;
    nrst = 0;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1;

    // Reset values
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 1);
    check("rst_arready", arready, 1);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    check("rst_irq", irq, 0);

    axi_read(BASE + 32'h10, 0, g1);
    check("cmp_lo_reset", g1, 32'hFFFF_FFFF);
    check("cmp_lo_rresp", rresp, 2'b00);
    axi_read(BASE + 32'h14, 1, g1);
    check("cmp_hi_reset", g1, 32'hFFFF_FFFF);
    check("irq_after_reset", irq, 0);

    // Prescale 3 with AW two cycles ahead of W, bready held off 5 cycles
    axi_write(BASE + 32'h04, 32'h0000_0003, 4'hF, 2, 5);
    axi_write(BASE + 32'h00, 32'h1, 4'hF, 0, 0);
    axi_read(BASE + 32'h08, 0, g1);
    repeat (6) cyc();
    axi_read(BASE + 32'h08, 0, g2);
    check("prescale4_rate", g2 - g1, 2);
    axi_write(BASE + 32'h04, 32'h0000_0001, 4'h1, -1, 1);

    // Compare / interrupt / W1C stickiness
    axi_write(BASE + 32'h00, 32'h0, 4'hF, 0, 0);
    axi_write(BASE + 32'h04, 32'h0, 4'hF, 0, 0);
    axi_write(BASE + 32'h08, 32'h0, 4'hF, 0, 0);
    axi_write(BASE + 32'h0C, 32'h0, 4'hF, 0, 0);
    axi_write(BASE + 32'h14, 32'h0, 4'hF, 0, 0);
    axi_write(BASE + 32'h10, 32'h20, 4'hF, 0, 0);
    axi_write(BASE + 32'h00, 32'h3, 4'hF, 0, 0);
    repeat (45) cyc();
    check("irq_match", irq, 1);
    axi_write(BASE + 32'h18, 32'h1, 4'hF, 0, 0);
    axi_read(BASE + 32'h18, 0, g1);
    check("match_sticky", g1, 1);
    axi_write(BASE + 32'h10, 32'h1000, 4'hF, 0, 0);
    axi_read(BASE + 32'h18, 0, g1);
    check("match_held_after_cmp", g1, 1);
    axi_write(BASE + 32'h18, 32'h1, 4'hF, 1, 0);
    axi_read(BASE + 32'h18, 0, g1);
    check("match_cleared", g1, 0);
    check("irq_cleared", irq, 0);

    // 32-bit carry, optionally across a LO/HI snapshot pair
    axi_write(BASE + 32'h00, 32'h0, 4'hF, 0, 0);
    axi_write(BASE + 32'h04, 32'd30, 4'hF, 0, 0);
    axi_write(BASE + 32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(BASE + 32'h0C, 32'h0, 4'hF, 0, 0);
    axi_write(BASE + 32'h00, 32'h1, 4'hF, 0, 0);
    axi_read(BASE + 32'h08, 0, g1);
    check("lo_pre_carry", g1, 32'hFFFF_FFFF);
    repeat (40) cyc();
    axi_read(BASE + 32'h0C, 0, g2);
`ifdef TIMER_SNAPSHOT_EN
    check("hi_snapshot", g2, 0);
`else
    check("hi_live", g2, 1);
`endif
    axi_read(BASE + 32'h08, 0, g1);
    check("lo_post_carry", g1, 0);
    axi_read(BASE + 32'h0C, 0, g2);
    check("hi_post_carry", g2, 1);

    // Error responses
    axi_read(BASE + 32'h1C, 0, g1);
    check("rresp_slverr", rresp, 2'b10);
    axi_write(BASE + 32'h02, 32'hFFFF_FFFF, 4'hF, 0, 0);
    check("bresp_slverr", bresp, 2'b10);
    axi_write(BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF, -2, 0);
    axi_read(BASE + 32'h04, 0, g1);
    check("prescale_unchanged", g1, 30);
    axi_read(BASE + 32'h00, 0, g1);
    check("ctrl_unchanged", g1, 1);

    // Same-cycle read and write of COUNT_LO
    axi_write(BASE + 32'h04, 32'h0, 4'hF, 0, 0);
    axi_read(BASE + 32'h08, 0, g1);
    rw_same(BASE + 32'h08, 32'h55, old);
    check("rw_old_value", old == 32'h55, 0);
    axi_read(BASE + 32'h08, 0, g2);
    check("rw_new_value_ge", g2 >= 32'h55, 1);

    // Randomized mixed traffic
    for (int i = 0; i < 40; i++) begin
      off = $urandom_range(0, 8) * 4;
      if ($urandom_range(0, 7) == 0) off = off | $urandom_range(1, 3);
      d = $urandom;
      if (off[4:0] == 5'h04) d = $urandom_range(0, 5);
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0)
        axi_write(BASE + off, d, s, int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 3)));
      else
        axi_read(BASE + off, int'($urandom_range(0, 3)), g1);
      repeat ($urandom_range(0, 3)) cyc();
    end

    // Reset in the middle of a write response
    awaddr = BASE + 32'h08; awvalid = 1; wdata = 32'h1234; wstrb = 4'hF; wvalid = 1;
    araddr = BASE + 32'h10; arvalid = 1;
    p_wr = 1; p_wr_addr = BASE + 32'h08; p_wdata = 32'h1234; p_wstrb = 4'hF;
    p_rd = 1; p_rd_addr = BASE + 32'h10;
    cyc();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("pre_abort_bvalid", bvalid, 1);
    #2 nrst = 0;
    #1;
    check("abort_bvalid", bvalid, 0);
    check("abort_rvalid", rvalid, 0);
    check("abort_awready", awready, 1);
    check("abort_arready", arready, 1);
    check("abort_rdata", rdata, 0);
    @(negedge clk);
    nrst = 1;
    model_reset();
    axi_read(BASE + 32'h08, 0, g1);
    check("count_after_abort", g1, 0);
    axi_read(BASE + 32'h10, 0, g1);
    check("cmp_after_abort", g1, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
